// File: rtl/pipe_pkg.sv
// Shared field layout for the pipeline-boundary registers: control bit positions
// and EX/MEM payload offsets, used by the stage wrappers to pack and unpack records.
package pipe_pkg;

    localparam int CTRL_REGW       = 0;
    localparam int CTRL_MEMR       = 1;
    localparam int CTRL_MEMW       = 2;
    localparam int CTRL_MDATAS     = 3;
    localparam int CTRL_SELMOD_LSB = 4;
    localparam int CTRL_SELMOD_MSB = 5;

    // EX/MEM payload: ALU result, store data, destination register index
    localparam int EXMEM_ALU_LSB = 0;
    localparam int EXMEM_ALU_MSB = 31;
    localparam int EXMEM_STD_LSB = 32;
    localparam int EXMEM_STD_MSB = 55;
    localparam int EXMEM_RD_LSB  = 56;
    localparam int EXMEM_RD_MSB  = 60;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-boundary register: valid/ready handshake with a 2-entry skid
// buffer, so in_ready is registered and never depends on out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 8,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    function automatic entry_t pack_entry(input logic [DATA_W-1:0] d,
                                          input logic [CTRL_W-1:0] c);
        entry_t e;
        e.data = d;
        e.ctrl = c;
        return e;
    endfunction

    entry_t m_q, m_d, s_q, s_d;
    logic   mv_q, mv_d, sv_q, sv_d;
    logic   in_fire, out_fire, squash;

    assign squash   = rst | flush;
    assign in_fire  = in_valid & ~sv_q;
    assign out_fire = mv_q & out_ready;

    always_comb begin
        m_d  = m_q;
        s_d  = s_q;
        mv_d = mv_q;
        sv_d = sv_q;
        if (!mv_q) begin
            if (in_fire) begin
                m_d  = pack_entry(in_data, in_ctrl);
                mv_d = 1'b1;
            end
        end else if (!sv_q) begin
            if (out_fire && in_fire) begin
                m_d = pack_entry(in_data, in_ctrl);
            end else if (out_fire) begin
                mv_d = 1'b0;
            end else if (in_fire) begin
                s_d  = pack_entry(in_data, in_ctrl);
                sv_d = 1'b1;
            end
        end else if (out_fire) begin
            // Skid drains into main; in_ready is low this cycle so no input arrives
            m_d  = s_q;
            sv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (squash) begin
            mv_q   <= 1'b0;
            sv_q   <= 1'b0;
            m_q.ctrl <= '0;
            s_q.ctrl <= '0;
        end else begin
            mv_q   <= mv_d;
            sv_q   <= sv_d;
            m_q.ctrl <= m_d.ctrl;
            s_q.ctrl <= s_d.ctrl;
        end
    end

    // Payload is only cleared when CLEAR_DATA is set; otherwise it keeps its old value on squash
    always_ff @(posedge clk) begin
        if (squash) begin
            if (CLEAR_DATA != 0) begin
                m_q.data <= '0;
                s_q.data <= '0;
            end
        end else begin
            m_q.data <= m_d.data;
            s_q.data <= s_d.data;
        end
    end

    assign out_valid = mv_q;
    assign in_ready  = ~sv_q;
    assign occupancy = {1'b0, mv_q} + {1'b0, sv_q};
    assign out_data  = m_q.data;
    assign out_ctrl  = mv_q ? m_q.ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed and random traffic against a depth-2 FIFO model.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [1:0]  occupancy;

    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [63:0] n_in_data, n_out_data;
    logic [7:0]  n_in_ctrl, n_out_ctrl;
    logic [1:0]  n_occupancy;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .CLEAR_DATA(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .CLEAR_DATA(0)) dut_nc (
        .clk(clk), .rst(rst), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_ctrl(n_out_ctrl), .occupancy(n_occupancy)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    last_in_fire;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, compare outputs with the model, advance one cycle.
    task automatic step(input bit chk, input logic vi, input logic [63:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl, input logic r);
        bit     in_fire, out_fire;
        item_t  it;
        rst = r; flush = fl; in_valid = vi; in_data = d; in_ctrl = c; out_ready = ordy;
        #1;
        if (chk) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            check("occupancy", {62'd0, occupancy}, 64'(q.size()));
            check("out_ctrl", {56'd0, out_ctrl}, (q.size() > 0) ? {56'd0, q[0].c} : 64'd0);
            if (q.size() > 0) check("out_data", out_data, q[0].d);
        end
        in_fire  = vi && (q.size() < 2);
        out_fire = ordy && (q.size() > 0);
        last_in_fire = in_fire && !(r || fl);
        if (r || fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
                it.d = d;
                it.c = c;
                q.push_back(it);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int accepted;
        int cyc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_in_ctrl = '0; n_out_ready = 1'b0;
        @(negedge clk);

        // 1: reset with in_valid asserted
        step(0, 1, 64'h77, 8'h3C, 0, 0, 1);
        step(0, 1, 64'h77, 8'h3C, 0, 0, 1);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_occupancy", {62'd0, occupancy}, 64'd0);
        check("rst_nc_out_valid", {63'd0, n_out_valid}, 64'd0);

        // 2: stream 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) step(1, 1, 64'(i), 8'(i), 1, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 64'd0, 8'd0, 1, 0, 0);

        // 3: backpressure fills the skid, then drains in order
        step(1, 1, 64'hA, 8'h11, 0, 0, 0);
        step(1, 1, 64'hB, 8'h22, 0, 0, 0);
        step(1, 1, 64'hC, 8'h33, 0, 0, 0);
        step(1, 1, 64'hC, 8'h33, 0, 0, 0);
        step(1, 1, 64'hC, 8'h33, 1, 0, 0);
        step(1, 1, 64'hC, 8'h33, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 64'd0, 8'd0, 1, 0, 0);

        // 4: flush a full stage while 0xC is offered
        step(1, 1, 64'hA, 8'hFF, 0, 0, 0);
        step(1, 1, 64'hB, 8'hFF, 0, 0, 0);
        step(1, 1, 64'hC, 8'hFF, 0, 1, 0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_data", out_data, 64'd0);
        step(1, 0, 64'd0, 8'd0, 1, 0, 0);
        step(1, 0, 64'd0, 8'd0, 1, 0, 0);

        // 5: random traffic with occasional flushes
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            step(1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0), 0);
            if (last_in_fire) accepted++;
            cyc++;
        end
        check("random_items_accepted", 64'(accepted), 64'd10000);
        for (int i = 0; i < 3; i++) step(1, 0, 64'd0, 8'd0, 1, 0, 0);
        check("drained", 64'(q.size()), 64'd0);

        // 6: CLEAR_DATA=0 keeps payload across flush while control is squashed
        n_in_valid = 1'b1; n_in_data = 64'h55; n_in_ctrl = 8'hA5;
        @(posedge clk); @(negedge clk);
        n_in_valid = 1'b0;
        check("nc_loaded_valid", {63'd0, n_out_valid}, 64'd1);
        check("nc_loaded_ctrl", {56'd0, n_out_ctrl}, 64'hA5);
        check("nc_loaded_data", n_out_data, 64'h55);
        n_flush = 1'b1;
        @(posedge clk); @(negedge clk);
        n_flush = 1'b0;
        check("nc_flush_valid", {63'd0, n_out_valid}, 64'd0);
        check("nc_flush_ctrl", {56'd0, n_out_ctrl}, 64'd0);
        check("nc_flush_data", n_out_data, 64'h55);
        check("nc_flush_occupancy", {62'd0, n_occupancy}, 64'd0);
        check("nc_flush_in_ready", {63'd0, n_in_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
